// File: rtl/mem_access_unit_if.sv
// Data-memory bus between the MEM-stage access unit and the data memory.
// master: the access unit (drives request, write strobe, mask, address, data;
//         receives grant, read-valid and read data).
// slave:  the memory (the mirror image).
interface mem_access_unit_if #(
    parameter int unsigned XLEN = 32
);
    logic            dm_req;
    logic            dm_web;
    logic [XLEN-1:0] dm_bweb;
    logic [XLEN-1:0] dm_addr;
    logic [XLEN-1:0] dm_wdata;
    logic            dm_gnt;
    logic            dm_rvalid;
    logic [XLEN-1:0] dm_rdata;

    modport master (
        output dm_req, dm_web, dm_bweb, dm_addr, dm_wdata,
        input  dm_gnt, dm_rvalid, dm_rdata
    );

    modport slave (
        input  dm_req, dm_web, dm_bweb, dm_addr, dm_wdata,
        output dm_gnt, dm_rvalid, dm_rdata
    );
endinterface

// File: rtl/mem_access_unit.sv
// MEM-stage access unit. Issues loads/stores from the EX/MEM register to the
// data memory, stalls the pipeline until the access completes, aligns and
// extends load data, and registers the MEM/WB outputs.
// Ports:
//   clk, rst           clock; asynchronous active-high reset
//   M_*                EX/MEM pipeline register outputs (held stable while stalled)
//   dm                 data-memory bus (master side)
//   mem_stall          hold IF/ID/EX and EX/MEM this cycle
//   W_*                registered MEM/WB outputs
module mem_access_unit #(
    parameter int unsigned XLEN     = 32,
    parameter logic [6:0]  OP_LOAD  = 7'b0000011,
    parameter logic [6:0]  OP_STORE = 7'b0100011
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [6:0]        M_op,
    input  logic [4:0]        M_rd,
    input  logic [2:0]        M_funct3,
    input  logic              M_reg_write_enable,
    input  logic              M_wb_data_sel,
    input  logic [XLEN-1:0]   M_dm_write_enable,
    input  logic              M_web,
    input  logic [XLEN-1:0]   M_alu_out,
    input  logic [XLEN-1:0]   M_dm_data,
    mem_access_unit_if.master dm,
    output logic              mem_stall,
    output logic [4:0]        W_rd,
    output logic              W_reg_write_enable,
    output logic [XLEN-1:0]   W_wb_data
);
    typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

    state_t          state, state_next;
    logic            is_ld, is_st, is_mem;
    logic            done;
    logic [7:0]      ld_byte;
    logic [15:0]     ld_half;
    logic [XLEN-1:0] ld_ext;

    // The write decision comes from the opcode; the upstream strobe is unused.
    logic unused_web;
    assign unused_web = M_web;

    assign is_ld  = (M_op == OP_LOAD);
    assign is_st  = (M_op == OP_STORE);
    assign is_mem = is_ld | is_st;

    assign dm.dm_web   = ~is_st;
    assign dm.dm_addr  = M_alu_out;
    assign dm.dm_wdata = M_dm_data;
    assign dm.dm_bweb  = M_dm_write_enable;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // dm_rvalid is only looked at in RESP, so a response coinciding with the
    // grant or arriving after an abandoned access is dropped.
    always_comb begin
        state_next = state;
        dm.dm_req  = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (is_mem) begin
                    dm.dm_req = 1'b1;
                    if (dm.dm_gnt) begin
                        if (is_st) done = 1'b1;
                        else       state_next = RESP;
                    end else begin
                        state_next = REQ;
                    end
                end
            end
            REQ: begin
                dm.dm_req = 1'b1;
                if (dm.dm_gnt) begin
                    done       = is_st;
                    state_next = is_ld ? RESP : IDLE;
                end
            end
            RESP: begin
                if (dm.dm_rvalid) begin
                    done       = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign mem_stall = is_mem & ~done;

    always_comb begin
        case (M_alu_out[1:0])
            2'd0:    ld_byte = dm.dm_rdata[7:0];
            2'd1:    ld_byte = dm.dm_rdata[15:8];
            2'd2:    ld_byte = dm.dm_rdata[23:16];
            default: ld_byte = dm.dm_rdata[31:24];
        endcase
        ld_half = M_alu_out[1] ? dm.dm_rdata[31:16] : dm.dm_rdata[15:0];
        case (M_funct3)
            3'b000:  ld_ext = {{24{ld_byte[7]}}, ld_byte};
            3'b100:  ld_ext = {24'h000000, ld_byte};
            3'b001:  ld_ext = {{16{ld_half[15]}}, ld_half};
            3'b101:  ld_ext = {16'h0000, ld_half};
            default: ld_ext = dm.dm_rdata;
        endcase
    end

    // While stalled, a bubble goes down the pipe and the data fields hold.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            W_rd               <= '0;
            W_reg_write_enable <= 1'b0;
            W_wb_data          <= '0;
        end else if (mem_stall) begin
            W_reg_write_enable <= 1'b0;
        end else begin
            W_rd               <= M_rd;
            W_reg_write_enable <= M_reg_write_enable & (M_rd != 5'd0);
            W_wb_data          <= M_wb_data_sel ? ld_ext : M_alu_out;
        end
    end
endmodule

// File: tb/tb_mem_access_unit.sv
module tb_mem_access_unit;
    localparam logic [6:0] OP_LD  = 7'b0000011;
    localparam logic [6:0] OP_ST  = 7'b0100011;
    localparam logic [6:0] OP_ALU = 7'b0110011;
    localparam logic [6:0] OP_NOP = 7'b0000000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [6:0]  M_op = OP_NOP;
    logic [4:0]  M_rd = '0;
    logic [2:0]  M_funct3 = '0;
    logic        M_reg_write_enable = 1'b0;
    logic        M_wb_data_sel = 1'b0;
    logic [31:0] M_dm_write_enable = '1;
    logic        M_web = 1'b1;
    logic [31:0] M_alu_out = '0;
    logic [31:0] M_dm_data = '0;
    logic        mem_stall;
    logic [4:0]  W_rd;
    logic        W_reg_write_enable;
    logic [31:0] W_wb_data;

    mem_access_unit_if #(.XLEN(32)) bus ();

    mem_access_unit #(.XLEN(32), .OP_LOAD(OP_LD), .OP_STORE(OP_ST)) dut (
        .clk(clk), .rst(rst),
        .M_op(M_op), .M_rd(M_rd), .M_funct3(M_funct3),
        .M_reg_write_enable(M_reg_write_enable), .M_wb_data_sel(M_wb_data_sel),
        .M_dm_write_enable(M_dm_write_enable), .M_web(M_web),
        .M_alu_out(M_alu_out), .M_dm_data(M_dm_data),
        .dm(bus.master),
        .mem_stall(mem_stall),
        .W_rd(W_rd), .W_reg_write_enable(W_reg_write_enable), .W_wb_data(W_wb_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  rd;
        logic        we;
        logic [31:0] wb;
        int          stalls;
        int          gw;
        logic        is_mem;
        logic        web;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] bweb;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad = 0;
    int   issue_id = 0;
    logic active = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h @%0t", nm, act, exp, $time);
        end
    endtask

    // Monitor: checks bus outputs each cycle of an instruction, and after it
    // retires (mem_stall low) compares the captured W_* with the queued entry.
    int   seen_id = -1;
    int   cyc = 0;
    logic pending = 1'b0;
    exp_t cur, ret;
    always @(negedge clk) begin
        if (pending) begin
            pending = 1'b0;
            chk("W_rd", {27'b0, W_rd}, {27'b0, ret.rd});
            chk("W_we", {31'b0, W_reg_write_enable}, {31'b0, ret.we});
            chk("W_wb_data", W_wb_data, ret.wb);
        end
        if (active && q.size() > 0) begin
            if (issue_id != seen_id) begin
                seen_id = issue_id;
                cyc = 0;
            end
            cur = q[0];
            chk("dm_req", {31'b0, bus.dm_req}, {31'b0, cur.is_mem && cyc <= cur.gw});
            if (cyc == 0 && cur.is_mem) begin
                chk("dm_web", {31'b0, bus.dm_web}, {31'b0, cur.web});
                chk("dm_addr", bus.dm_addr, cur.addr);
                chk("dm_wdata", bus.dm_wdata, cur.wdata);
                chk("dm_bweb", bus.dm_bweb, cur.bweb);
            end
            if (cyc >= 1)
                chk("bubble_we", {31'b0, W_reg_write_enable}, 32'd0);
            if (!mem_stall) begin
                chk("stall_cycles", cyc, cur.stalls);
                ret = q.pop_front();
                pending = 1'b1;
            end
            cyc++;
        end
    end

    task automatic idle_inputs();
        M_op = OP_NOP; M_rd = '0; M_funct3 = '0; M_reg_write_enable = 1'b0;
        M_wb_data_sel = 1'b0; M_dm_write_enable = '1; M_alu_out = '0; M_dm_data = '0;
        bus.dm_gnt = 1'b0; bus.dm_rvalid = 1'b0; bus.dm_rdata = '0;
    endtask

    // Presents one instruction; grant at cycle gw, rvalid rw cycles later
    // (early=1 adds an rvalid coincident with the grant, which must be ignored).
    task automatic issue(input logic [6:0] op, input logic [2:0] f3, input logic [4:0] rd,
                         input logic rwe, input logic sel, input logic [31:0] bweb,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [31:0] rdata, input int gw, input int rw,
                         input logic early, input logic [31:0] exp_wb,
                         input logic exp_we, input int exp_stalls);
        exp_t e;
        int   c;
        logic ld;
        e.rd = rd; e.we = exp_we; e.wb = exp_wb; e.stalls = exp_stalls; e.gw = gw;
        e.is_mem = (op == OP_LD) || (op == OP_ST); e.web = (op != OP_ST);
        e.addr = addr; e.wdata = wdata; e.bweb = bweb;
        q.push_back(e);
        ld = (op == OP_LD);
        M_op = op; M_funct3 = f3; M_rd = rd; M_reg_write_enable = rwe;
        M_wb_data_sel = sel; M_dm_write_enable = bweb; M_alu_out = addr;
        M_dm_data = wdata; bus.dm_rdata = rdata;
        issue_id++;
        active = 1'b1;
        c = 0;
        forever begin
            bus.dm_gnt    = e.is_mem && (c == gw);
            bus.dm_rvalid = ld && ((c == gw + rw) || (early && c == gw));
            @(negedge clk);
            if (!mem_stall) break;
            if (c > 60) begin
                total++; bad++;
                $display("FAIL timeout got=stalled exp=done @%0t", $time);
                q.delete();
                break;
            end
            @(posedge clk); #1;
            c++;
        end
        @(posedge clk); #1;
        active = 1'b0;
        idle_inputs();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got=running exp=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        idle_inputs();
        #12;
        chk("rst_W_rd", {27'b0, W_rd}, 32'd0);
        chk("rst_W_we", {31'b0, W_reg_write_enable}, 32'd0);
        chk("rst_W_wb", W_wb_data, 32'd0);
        chk("rst_stall", {31'b0, mem_stall}, 32'd0);
        @(posedge clk); #1 rst = 1'b0;
        @(posedge clk); #1;

        //     op      f3      rd  we  sel  bweb          addr          wdata         rdata         gw rw e  exp_wb        we stall
        issue(OP_ALU, 3'b000, 5,  1, 0, 32'hFFFF_FFFF, 32'h0000_1234, 32'h0,        32'h0,        0, 0, 0, 32'h0000_1234, 1, 0);
        issue(OP_LD,  3'b000, 6,  1, 1, 32'hFFFF_FFFF, 32'h0000_0103, 32'h0,        32'h80FF_0000, 0, 1, 0, 32'hFFFF_FF80, 1, 1);
        issue(OP_LD,  3'b101, 8,  1, 1, 32'hFFFF_FFFF, 32'h0000_0202, 32'h0,        32'hBEEF_1234, 2, 3, 0, 32'h0000_BEEF, 1, 5);
        issue(OP_ST,  3'b010, 0,  0, 0, 32'h0000_0000, 32'h0000_0300, 32'hDEAD_BEEF, 32'h0,       0, 0, 0, 32'h0000_0300, 0, 0);
        issue(OP_ST,  3'b010, 0,  0, 0, 32'h0000_0000, 32'h0000_0304, 32'h1234_5678, 32'h0,       1, 0, 0, 32'h0000_0304, 0, 1);
        issue(OP_LD,  3'b010, 0,  1, 1, 32'hFFFF_FFFF, 32'h0000_0400, 32'h0,        32'hCAFE_F00D, 0, 1, 0, 32'hCAFE_F00D, 0, 1);
        issue(OP_LD,  3'b001, 9,  1, 1, 32'hFFFF_FFFF, 32'h0000_0011, 32'h0,        32'h1234_8001, 0, 1, 0, 32'hFFFF_8001, 1, 1);
        issue(OP_LD,  3'b100, 10, 1, 1, 32'hFFFF_FFFF, 32'h0000_0502, 32'h0,        32'h00AB_0000, 0, 2, 0, 32'h0000_00AB, 1, 2);
        issue(OP_LD,  3'b000, 11, 1, 1, 32'hFFFF_FFFF, 32'h0000_0701, 32'h0,        32'h0000_7F00, 0, 1, 0, 32'h0000_007F, 1, 1);
        issue(OP_LD,  3'b010, 12, 1, 1, 32'hFFFF_FFFF, 32'h0000_0800, 32'h0,        32'h0BAD_F00D, 1, 2, 1, 32'h0BAD_F00D, 1, 3);

        // Reset while a load waits in RESP; later rvalid must be ignored.
        M_op = OP_LD; M_funct3 = 3'b010; M_rd = 5'd7; M_reg_write_enable = 1'b1;
        M_wb_data_sel = 1'b1; M_alu_out = 32'h0000_0600; bus.dm_rdata = 32'h5555_AAAA;
        bus.dm_gnt = 1'b1;
        @(posedge clk); #1 bus.dm_gnt = 1'b0;
        @(negedge clk);
        chk("resp_stall", {31'b0, mem_stall}, 32'd1);
        rst = 1'b1;
        idle_inputs();
        #1;
        chk("midrst_W_rd", {27'b0, W_rd}, 32'd0);
        chk("midrst_W_we", {31'b0, W_reg_write_enable}, 32'd0);
        chk("midrst_W_wb", W_wb_data, 32'd0);
        chk("midrst_stall", {31'b0, mem_stall}, 32'd0);
        @(posedge clk); #1 rst = 1'b0;
        bus.dm_rvalid = 1'b1;
        @(posedge clk); #1 bus.dm_rvalid = 1'b0;
        issue(OP_ALU, 3'b000, 13, 1, 0, 32'hFFFF_FFFF, 32'h0000_00AA, 32'h0,        32'h0,        0, 0, 0, 32'h0000_00AA, 1, 0);
        issue(OP_LD,  3'b010, 14, 1, 1, 32'hFFFF_FFFF, 32'h0000_0900, 32'h0,        32'h1357_9BDF, 2, 1, 1, 32'h1357_9BDF, 1, 3);

        repeat (3) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
